// File: rtl/mixsx_idx_gen_pkg.sv
// Shared types and helpers for the mixsx index generator.
package mixsx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      HOLD
   } idx_state_t;

   localparam int unsigned MIXSX_WORD_W = 64;

   // Number of whole index fields that fit in one random word.
   function automatic int unsigned fields_per_word(input int unsigned idx_w);
      return MIXSX_WORD_W / idx_w;
   endfunction

endpackage

// File: rtl/mixsx_idx_gen_if.sv
// Handshake bundle between the index generator and its producer/consumer.
// master: drives start, the word stream and d_ready; slave: the generator.
interface mixsx_idx_gen_if #(
   parameter int unsigned CWORDS64 = 2,
   parameter int unsigned XWORDS32 = 2
);
   localparam int unsigned IDX_WIDTH = $clog2(XWORDS32);

   logic                            start;
   logic [63:0]                     in_word;
   logic                            in_valid;
   logic                            in_ready;
   logic [CWORDS64*IDX_WIDTH-1:0]   d;
   logic                            d_valid;
   logic                            d_ready;
   logic                            busy;

   modport master (
      output start, in_word, in_valid, d_ready,
      input  in_ready, d, d_valid, busy
   );

   modport slave (
      input  start, in_word, in_valid, d_ready,
      output in_ready, d, d_valid, busy
   );
endinterface

// File: rtl/mixsx_word_unpack.sv
// Single-word buffer that slices a 64-bit random word into IDX_WIDTH-bit
// fields, LSB first, one field per cycle while enabled.
module mixsx_word_unpack
   import mixsx_pkg::*;
#(
   parameter int unsigned IDX_WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 flush,
   input  logic [63:0]          in_word,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [IDX_WIDTH-1:0] field,
   output logic                 field_valid
);
   localparam int unsigned FPW = fields_per_word(IDX_WIDTH);
   localparam int unsigned KW  = (FPW > 1) ? $clog2(FPW) : 1;

   logic [63:0]   buf_q;
   logic [KW-1:0] k_q;
   logic          full_q;

   // Accept only into an empty buffer; present the current field when full.
   always_comb begin
      in_ready    = enable && !full_q;
      field_valid = enable && full_q;
      field       = IDX_WIDTH'(buf_q >> (k_q * IDX_WIDTH));
   end

   // Buffer load, field pointer advance and empty-on-last-field / flush.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_q  <= '0;
         k_q    <= '0;
         full_q <= 1'b0;
      end else if (flush) begin
         k_q    <= '0;
         full_q <= 1'b0;
      end else if (in_valid && in_ready) begin
         buf_q  <= in_word;
         k_q    <= '0;
         full_q <= 1'b1;
      end else if (field_valid) begin
         if (k_q == KW'(FPW - 1)) begin
            k_q    <= '0;
            full_q <= 1'b0;
         end else begin
            k_q <= k_q + 1'b1;
         end
      end
   end
endmodule

// File: rtl/mixsx_idx_gen.sv
// Index-vector generator for the mixsx32 d input.
// Optional feature: define MIXSX_IDX_REJECT_EN for rejection sampling of
// out-of-range fields; otherwise out-of-range fields are reduced by XWORDS32.
module mixsx_idx_gen
   import mixsx_pkg::*;
#(
   parameter int unsigned CWORDS64 = 2,
   parameter int unsigned XWORDS32 = 2
) (
   input logic             clk,
   input logic             reset,
   mixsx_idx_gen_if.slave  bus
);
   localparam int unsigned IDX_WIDTH = $clog2(XWORDS32);
   localparam int unsigned NW        = $clog2(CWORDS64 + 1);
   localparam int unsigned DW        = CWORDS64 * IDX_WIDTH;

   idx_state_t           state_q, state_d;
   logic [NW-1:0]        n_q, n_d;
   logic [DW-1:0]        d_q, d_d;
   logic                 flush;
   logic [IDX_WIDTH-1:0] field;
   logic                 field_valid;
   logic [31:0]          field_ext;
   logic                 accept;
   logic [IDX_WIDTH-1:0] slot_val;

   mixsx_word_unpack #(
      .IDX_WIDTH (IDX_WIDTH)
   ) u_unpack (
      .clk         (clk),
      .reset       (reset),
      .enable      (state_q == FILL),
      .flush       (flush),
      .in_word     (bus.in_word),
      .in_valid    (bus.in_valid),
      .in_ready    (bus.in_ready),
      .field       (field),
      .field_valid (field_valid)
   );

   // Validate or reduce the current field against the index range.
   always_comb begin
      field_ext = 32'(field);
`ifdef MIXSX_IDX_REJECT_EN
      accept   = field_valid && (field_ext < XWORDS32);
      slot_val = field;
`else
      accept   = field_valid;
      slot_val = (field_ext >= XWORDS32) ? IDX_WIDTH'(field_ext - XWORDS32) : field;
`endif
   end

   // Next state, slot write and buffer flush decisions.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      d_d     = d_q;
      flush   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = FILL;
               n_d     = '0;
               flush   = 1'b1;
            end
         end
         FILL: begin
            if (accept) begin
               for (int unsigned s = 0; s < CWORDS64; s++) begin
                  if (n_q == NW'(s)) d_d[s*IDX_WIDTH +: IDX_WIDTH] = slot_val;
               end
               n_d = NW'(n_q + 1'b1);
               // Last slot: drop the remainder of the buffered word.
               if (n_q == NW'(CWORDS64 - 1)) begin
                  state_d = HOLD;
                  flush   = 1'b1;
               end
            end
         end
         HOLD: begin
            if (bus.d_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, slot counter and output vector registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         n_q     <= '0;
         d_q     <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         d_q     <= d_d;
      end
   end

   // Registered vector and status flags.
   always_comb begin
      bus.d       = d_q;
      bus.d_valid = (state_q == HOLD);
      bus.busy    = (state_q != IDLE);
   end
endmodule

// File: tb/tb_mixsx_idx_gen.sv
// Scoreboard bench for mixsx_idx_gen: instance A (XWORDS32=3, CWORDS64=2)
// and instance B (XWORDS32=65536, CWORDS64=5).
module tb_mixsx_idx_gen;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mixsx_idx_gen_if #(.CWORDS64(2), .XWORDS32(3))     ifa ();
   mixsx_idx_gen_if #(.CWORDS64(5), .XWORDS32(65536)) ifb ();

   mixsx_idx_gen #(.CWORDS64(2), .XWORDS32(3)) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa.slave)
   );

   mixsx_idx_gen #(.CWORDS64(5), .XWORDS32(65536)) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] wq_a[$];
   logic [63:0] wq_b[$];
   logic [3:0]  exp_a[$];
   logic [79:0] exp_b[$];
   int          acc_a = 0;
   int          acc_b = 0;
   bit          rnd_a = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   // Word feeders: present the queue head, pop on an observed accept.
   initial begin
      bit fire;
      ifa.in_valid = 1'b0;
      ifa.in_word  = '0;
      forever begin
         @(negedge clk);
         fire = ifa.in_valid && ifa.in_ready && !reset;
         @(posedge clk);
         #1;
         if (fire && wq_a.size() > 0) begin
            void'(wq_a.pop_front());
            acc_a++;
         end
         if (wq_a.size() > 0 && (!rnd_a || $urandom_range(0, 1) == 1)) begin
            ifa.in_valid = 1'b1;
            ifa.in_word  = wq_a[0];
         end else begin
            ifa.in_valid = 1'b0;
            ifa.in_word  = {$urandom, $urandom};
         end
      end
   end

   initial begin
      bit fire;
      ifb.in_valid = 1'b0;
      ifb.in_word  = '0;
      forever begin
         @(negedge clk);
         fire = ifb.in_valid && ifb.in_ready && !reset;
         @(posedge clk);
         #1;
         if (fire && wq_b.size() > 0) begin
            void'(wq_b.pop_front());
            acc_b++;
         end
         ifb.in_valid = (wq_b.size() > 0);
         ifb.in_word  = (wq_b.size() > 0) ? wq_b[0] : 64'h0;
      end
   end

   // Monitors: compare each handed-off vector with the scoreboard head.
   bit         hold_a = 1'b0;
   logic [3:0] prev_d_a;

   always @(negedge clk) begin
      if (reset) begin
         hold_a = 1'b0;
      end else begin
         if (hold_a && ifa.d_valid) check("a_d_stable", ifa.d, prev_d_a);
         if (ifa.in_valid && ifa.in_ready)
            check("a_accept_in_fill", {ifa.busy, ifa.d_valid}, 2'b10);
         if (ifa.d_valid && ifa.d_ready) begin
            if (exp_a.size() == 0) fail("a_unexpected_vector");
            else check("a_d", ifa.d, exp_a.pop_front());
         end
         hold_a   = ifa.d_valid && !ifa.d_ready;
         prev_d_a = ifa.d;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (ifb.in_valid && ifb.in_ready)
            check("b_accept_in_fill", {ifb.busy, ifb.d_valid}, 2'b10);
         if (ifb.d_valid && ifb.d_ready) begin
            if (exp_b.size() == 0) fail("b_unexpected_vector");
            else check("b_d", ifb.d, exp_b.pop_front());
         end
      end
   end

   task automatic pulse_start_a(output int edges);
      ifa.start = 1'b1;
      @(posedge clk);
      #1;
      ifa.start = 1'b0;
      edges = 1;
      while (!ifa.d_valid && edges < 200) begin
         @(posedge clk);
         #1;
         edges++;
      end
      if (!ifa.d_valid) fail("a_dvalid_timeout");
   endtask

   task automatic pulse_start_b(output int edges);
      ifb.start = 1'b1;
      @(posedge clk);
      #1;
      ifb.start = 1'b0;
      edges = 1;
      while (!ifb.d_valid && edges < 200) begin
         @(posedge clk);
         #1;
         edges++;
      end
      if (!ifb.d_valid) fail("b_dvalid_timeout");
   endtask

   task automatic wait_idle_a();
      int cyc = 0;
      while (ifa.busy && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (ifa.busy) fail("a_idle_timeout");
   endtask

   task automatic wait_idle_b();
      int cyc = 0;
      while (ifb.busy && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (ifb.busy) fail("b_idle_timeout");
   endtask

   logic [63:0] b_words [6] = '{64'h4444_3333_2222_1111, 64'hAAAA_9999_8888_5555,
                                64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                64'hDDDD_CCCC_BBBB_AAAA, 64'h0000_0000_0000_EEEE};
   logic [79:0] b_exps  [3] = '{80'h5555_4444_3333_2222_1111,
                                80'h3210_0123_4567_89AB_CDEF,
                                80'hEEEE_DDDD_CCCC_BBBB_AAAA};
   logic [63:0] r_words [5] = '{64'hFFFF_FFFF_FFFF_FF06, 64'hFFFF_FFFF_FFFF_FF01,
                                64'hFFFF_FFFF_FFFF_FF09, 64'hFFFF_FFFF_FFFF_FF0A,
                                64'hFFFF_FFFF_FFFF_FF00};
   logic [3:0]  r_exps  [5] = '{4'b0110, 4'b0001, 4'b1001, 4'b1010, 4'b0000};

   initial begin
      int edges;
      int acc0;
      int cyc;
      reset       = 1'b1;
      ifa.start   = 1'b0;
      ifa.d_ready = 1'b1;
      ifb.start   = 1'b0;
      ifb.d_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("a_reset_state", {ifa.in_ready, ifa.d_valid, ifa.busy, ifa.d}, '0);
      check("b_reset_state", {ifb.in_ready, ifb.d_valid, ifb.busy, ifb.d}, '0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Reset after one slot written: outputs clear at once, no vector emitted.
      wq_a.push_back(64'h6);
      @(posedge clk);
      #1;
      ifa.start = 1'b1;
      @(posedge clk);
      #1;
      ifa.start = 1'b0;
      check("a_inready_after_start", ifa.in_ready, 1'b1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("a_mid_slot0", {ifa.busy, ifa.d_valid, ifa.d[1:0]}, 4'b1010);
      #1;
      reset = 1'b1;
      #1;
      check("a_mid_reset_clear", {ifa.in_ready, ifa.d_valid, ifa.busy, ifa.d}, '0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Low byte 3B: fields 3,2,3,0.
      wq_a.push_back(64'h3B);
`ifdef MIXSX_IDX_REJECT_EN
      exp_a.push_back(4'b0010);
`else
      exp_a.push_back(4'b1000);
`endif
      @(posedge clk);
      #1;
      acc0 = acc_a;
      pulse_start_a(edges);
`ifdef MIXSX_IDX_REJECT_EN
      check("a_latency_3b", edges, 6);
`else
      check("a_latency_3b", edges, 4);
`endif
      wait_idle_a();
      check("a_words_3b", acc_a - acc0, 1);

      // Consumer stall for 10 cycles.
      ifa.d_ready = 1'b0;
      wq_a.push_back(64'h6);
      exp_a.push_back(4'b0110);
      @(posedge clk);
      #1;
      pulse_start_a(edges);
      check("a_latency_06", edges, 4);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("a_hold", {ifa.d_valid, ifa.in_ready, ifa.busy, ifa.d}, {3'b101, 4'b0110});
      end
      ifa.d_ready = 1'b1;
      @(posedge clk);
      #1;
      check("a_idle_after_ready", {ifa.busy, ifa.d_valid}, 2'b00);
      check("a_d_kept_idle", ifa.d, 4'b0110);

      // Random in_valid with start held: back-to-back vectors.
      rnd_a = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wq_a.push_back(r_words[i]);
         exp_a.push_back(r_exps[i]);
      end
      ifa.start = 1'b1;
      cyc = 0;
      while (exp_a.size() > 0 && cyc < 500) begin
         @(posedge clk);
         cyc++;
      end
      #1;
      ifa.start = 1'b0;
      if (exp_a.size() > 0) fail("a_random_timeout");
      wait_idle_a();
      rnd_a = 1'b0;
      check("a_random_words_left", wq_a.size(), 0);

      // Instance B: 16-bit fields, two words per vector, tail of word 2 discarded.
      for (int v = 0; v < 3; v++) begin
         wq_b.push_back(b_words[2*v]);
         wq_b.push_back(b_words[2*v+1]);
         exp_b.push_back(b_exps[v]);
         @(posedge clk);
         #1;
         acc0 = acc_b;
         pulse_start_b(edges);
         check("b_latency", edges, 8);
         wait_idle_b();
         check("b_words", acc_b - acc0, 2);
         check("b_d_kept_idle", ifb.d, b_exps[v]);
      end

      repeat (3) @(posedge clk);
      #1;
      check("a_scoreboard_empty", exp_a.size(), 0);
      check("b_scoreboard_empty", exp_b.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/mixsx_idx_gen.md
# mixsx_idx_gen

Index-vector generator that feeds the `d` input of the mixsx32 stage. It consumes a stream of 64-bit pseudo-random words and slices them into `IDX_WIDTH`-bit candidate indices. Each candidate is validated or reduced against `XWORDS32`, and `CWORDS64` indices are packed into `d`. The finished vector is presented through a valid/ready handshake and held stable until mixsx32 takes it.

## Interface
Parameters:
- `CWORDS64`, default 2: number of indices per output vector; must be ≥1.
- `XWORDS32`, default 2: index range; legal indices are 0..XWORDS32-1; must be ≥2.
- `IDX_WIDTH`, localparam = $clog2(XWORDS32): bits per index field.
- `FPW`, localparam = 64/IDX_WIDTH (floor): fields per input word.

Ports (reset is asynchronous, active-high; clock is `clk`):
- `clk`, input, 1: clock.
- `reset`, input, 1: async active-high reset.
- `start`, input, 1: begin building one vector; sampled only in IDLE.
- `in_word`, input, 64: random word.
- `in_valid`, input, 1: `in_word` valid.
- `in_ready`, output, 1: word accepted on the edge where `in_valid && in_ready`.
- `d`, output, CWORDS64*IDX_WIDTH: packed indices; slot n is `d[n*IDX_WIDTH +: IDX_WIDTH]`.
- `d_valid`, output, 1: `d` complete and stable.
- `d_ready`, input, 1: consumer takes `d`.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, FILL, HOLD.
  - IDLE: if `start`, go to FILL and clear the slot counter `n` and the word buffer.
  - FILL: accept words and process one field per cycle. When `n` reaches CWORDS64, go to HOLD.
  - HOLD: `d_valid`=1. On `d_ready`, go to IDLE. `start` is ignored in HOLD.
- Word buffer:
  - `in_ready` = (state==FILL) && buffer empty.
  - An accepted word loads the buffer with field pointer `k`=0.
  - Each cycle the buffer is valid in FILL, field `k` = `word[k*IDX_WIDTH +: IDX_WIDTH]` is evaluated (LSB first), then `k` increments.
  - After field FPW-1 the buffer empties. Bits above FPW*IDX_WIDTH are ignored.
- Field evaluation:
  - If the field is accepted, write it to slot `n` and increment `n`.
  - When `n` becomes CWORDS64, the rest of the buffered word is discarded and the buffer empties.
- `d` is written only in FILL. It keeps its last value through IDLE until the next fill overwrites slots.
- When XWORDS32 is a power of two, every field is legal. In that case the `_EN` option below has no effect.
- Counters: `n` is $clog2(CWORDS64+1) bits. `k` is $clog2(FPW) bits and wraps to 0 on buffer empty.

## Timing
- Reset values: `in_ready`=0, `d_valid`=0, `busy`=0, `d`=0. State is IDLE, `n`=0, buffer empty.
- Reset mid-operation returns immediately to IDLE. The partial vector is lost and no `d_valid` pulse occurs.
- Cycle sequence:
  - `start` seen at edge E0 → FILL, with `in_ready`=1 during cycle E0..E1.
  - Word accepted at E1.
  - Fields are evaluated at E2, E3, and so on.
  - `d_valid` rises after the edge that writes slot CWORDS64-1.
  - Minimum latency from `start` to `d_valid`: CWORDS64+2 edges.
- No field is evaluated on the edge where a word is accepted. Throughput is one field per cycle plus one accept cycle per word.
- `in_valid` with `in_ready`=0 has no effect. Upstream must hold the word.
- `d_valid` and `d_ready` are both high at edge E → IDLE at E, and `d_valid` falls.
- `start` held high continuously gives back-to-back vectors, with one IDLE cycle between them.

## Configuration
- `MIXSX_IDX_REJECT_EN` defined: rejection sampling. A field ≥ XWORDS32 is dropped, and `n` is unchanged.
- `MIXSX_IDX_REJECT_EN` undefined: conditional reduction. A field ≥ XWORDS32 is replaced by field − XWORDS32, and every field is accepted.
- Without the macro, the output distribution is biased. Cycle count is then deterministic: ceil(CWORDS64/FPW) words.

## Structure
- Package `mixsx_pkg` holds:
  - the state enum `idx_state_t` {IDLE, FILL, HOLD};
  - the constant `MIXSX_WORD_W`=64;
  - a function `fields_per_word(idx_w)`.
- Sub-module `mixsx_word_unpack`: owns the 64-bit buffer, field pointer `k`, `in_ready`, and the field/field-valid output, plus a flush input. The top level holds the FSM, accept/reduce logic and the `d` register.

## Test plan
- XWORDS32=4, CWORDS64=2, `in_word`=64'h...E4, `start` pulse → `d`=4'b0100, `d_valid` after 4 edges, one word consumed.
- XWORDS32=3, CWORDS64=2, `in_word` low byte 8'h3B → `d`=4'b0010 with `MIXSX_IDX_REJECT_EN`; `d`=4'b1000 without it.
- XWORDS32=65536, CWORDS64=5, words W0 and W1 → slots 0–3 = W0 16-bit fields LSB first, slot 4 = W1[15:0], two accepts.
- `d_ready` held low for 10 cycles → `d` and `d_valid` stable, `in_ready`=0 throughout, then IDLE one edge after `d_ready`.
- Reset asserted mid-FILL after 1 slot written → all outputs 0 immediately; a new `start` produces a correct full vector.
- `in_valid` toggling randomly, `start` held high → every vector matches the reference-model slicing, and no word is accepted outside FILL.
